// File: rtl/traffic_phase_scheduler.sv
// Eight-phase traffic signal sequencer: demand/recall driven phase rotation with
// programmable green lengths, pedestrian walk service and emergency preemption.
module traffic_phase_scheduler #(
    parameter int          TICK_DIV      = 50000000,
    parameter int          YELLOW_TICKS  = 3,
    parameter int          ALLRED_TICKS  = 1,
    parameter int          DEFAULT_GREEN = 10,
    parameter logic [7:0]  RECALL_MASK   = 8'hFF
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cfg_we,
    input  logic [2:0] cfg_addr,
    input  logic [7:0] cfg_data,
    input  logic [7:0] veh_req,
    input  logic [3:0] ped_req,
    input  logic       preempt_req,
    input  logic [2:0] preempt_phase,
    output logic [2:0] phase,
    output logic [1:0] interval,
    output logic [7:0] remaining,
    output logic [3:0] walk,
    output logic       preempt_ack,
    output logic       phase_start
);

    typedef enum logic [1:0] {
        S_GREEN   = 2'b00,
        S_YELLOW  = 2'b01,
        S_ALLRED  = 2'b10,
        S_PREEMPT = 2'b11
    } state_t;

    localparam int          PW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_MAX = PW'(TICK_DIV - 1);
    localparam logic [7:0]  YEL_LEN   = (YELLOW_TICKS == 0) ? 8'd1 : 8'(YELLOW_TICKS);
    localparam logic [7:0]  AR_LEN    = (ALLRED_TICKS == 0) ? 8'd1 : 8'(ALLRED_TICKS);
    localparam logic [7:0]  DG_VAL    = 8'(DEFAULT_GREEN);

    state_t          state_q, state_d;
    logic [2:0]      phase_q, phase_d;
    logic [7:0]      rem_q, rem_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [2:0]      nxt_q, nxt_d;
    logic            pre_pend_q, pre_pend_d;
    logic [2:0]      pre_phase_q, pre_phase_d;
    logic [7:0]      veh_pend_q, veh_pend_d;
    logic [3:0]      ped_pend_q, ped_pend_d;
    logic [3:0]      walk_q, walk_d;
    logic            phase_start_q, phase_start_d;
    logic [7:0]      table_q [8];

    logic            tick;
    logic            green_entry;
    logic [3:0]      ped_hit;
    logic [7:0]      cand;
    logic [3:0]      pick_after;
    logic [3:0]      pick_from_nxt;
    logic [2:0]      green_ph;
    logic [2:0]      pre_tgt;
    logic            pre_any;

    // Zero-length intervals would never end on a tick, so they run one tick.
    function automatic logic [7:0] fix_len(input logic [7:0] v);
        return (v == 8'd0) ? 8'd1 : v;
    endfunction

    // First qualifying phase at start, start+1, ... (wrapping); bit 3 = found.
    function automatic logic [3:0] pick(input logic [7:0] c, input logic [2:0] start);
        logic [3:0] r;
        logic [2:0] idx;
        r = 4'b0000;
        for (int k = 7; k >= 0; k--) begin
            idx = start + 3'(k);
            if (c[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_table
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    table_q[gi] <= DG_VAL;
                else if (cfg_we && cfg_addr == 3'(gi))
                    table_q[gi] <= cfg_data;
            end
        end
    endgenerate

    assign tick          = (presc_q == PRESC_MAX);
    assign cand          = veh_pend_q | RECALL_MASK;
    assign pick_after    = pick(cand, phase_q + 3'd1);
    assign pick_from_nxt = pick(cand, nxt_q);
    assign green_ph      = pick_from_nxt[3] ? pick_from_nxt[2:0] : phase_q;
    assign pre_any       = pre_pend_q | preempt_req;
    assign pre_tgt       = pre_pend_q ? pre_phase_q : preempt_phase;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= S_ALLRED;
            phase_q       <= 3'd0;
            rem_q         <= AR_LEN;
            presc_q       <= '0;
            nxt_q         <= 3'd0;
            pre_pend_q    <= 1'b0;
            pre_phase_q   <= 3'd0;
            veh_pend_q    <= 8'd0;
            ped_pend_q    <= 4'd0;
            walk_q        <= 4'd0;
            phase_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            rem_q         <= rem_d;
            presc_q       <= presc_d;
            nxt_q         <= nxt_d;
            pre_pend_q    <= pre_pend_d;
            pre_phase_q   <= pre_phase_d;
            veh_pend_q    <= veh_pend_d;
            ped_pend_q    <= ped_pend_d;
            walk_q        <= walk_d;
            phase_start_q <= phase_start_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        rem_d         = rem_q;
        presc_d       = tick ? '0 : presc_q + 1'b1;
        nxt_d         = nxt_q;
        pre_pend_d    = pre_pend_q;
        pre_phase_d   = pre_phase_q;
        green_entry   = 1'b0;
        phase_start_d = 1'b0;

        // Target phase is captured once, when the request is first seen.
        if (preempt_req && !pre_pend_q && state_q != S_PREEMPT) begin
            pre_pend_d  = 1'b1;
            pre_phase_d = preempt_phase;
        end

        if (tick && rem_q > 8'd1)
            rem_d = rem_q - 8'd1;

        unique case (state_q)
            S_GREEN: begin
                if (preempt_req) begin
                    if (preempt_phase == phase_q) begin
                        state_d       = S_PREEMPT;
                        phase_d       = preempt_phase;
                        rem_d         = 8'd0;
                        presc_d       = '0;
                        pre_pend_d    = 1'b0;
                        phase_start_d = 1'b1;
                    end else begin
                        state_d = S_YELLOW;
                        rem_d   = YEL_LEN;
                        presc_d = '0;
                    end
                end else if (tick && rem_q == 8'd1) begin
                    if (!pick_after[3]) begin
                        rem_d = 8'd1;
                    end else if (pick_after[2:0] == phase_q) begin
                        rem_d         = fix_len(table_q[phase_q]);
                        presc_d       = '0;
                        green_entry   = 1'b1;
                        phase_start_d = 1'b1;
                    end else begin
                        state_d = S_YELLOW;
                        nxt_d   = pick_after[2:0];
                        rem_d   = YEL_LEN;
                        presc_d = '0;
                    end
                end
            end
            S_YELLOW: begin
                if (tick && rem_q == 8'd1) begin
                    state_d = S_ALLRED;
                    rem_d   = AR_LEN;
                    presc_d = '0;
                end
            end
            S_ALLRED: begin
                if (tick && rem_q == 8'd1) begin
                    presc_d       = '0;
                    phase_start_d = 1'b1;
                    if (pre_any) begin
                        state_d    = S_PREEMPT;
                        phase_d    = pre_tgt;
                        rem_d      = 8'd0;
                        pre_pend_d = 1'b0;
                    end else begin
                        state_d     = S_GREEN;
                        phase_d     = green_ph;
                        rem_d       = fix_len(table_q[green_ph]);
                        green_entry = 1'b1;
                    end
                end
            end
            S_PREEMPT: begin
                presc_d = '0;
                rem_d   = 8'd0;
                if (!preempt_req) begin
                    state_d = S_YELLOW;
                    rem_d   = YEL_LEN;
                    nxt_d   = phase_q + 3'd1;
                end
            end
            default: ;
        endcase
    end

    // Set-and-clear in the entry cycle leaves the pending bit clear.
    assign veh_pend_d = (veh_pend_q | veh_req) &
                        ~(green_entry ? (8'b1 << phase_d) : 8'b0);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_ped
            assign ped_hit[gi]    = green_entry && (phase_d == 3'(2 * gi));
            assign ped_pend_d[gi] = ped_hit[gi] ? 1'b0 : (ped_pend_q[gi] | ped_req[gi]);
            assign walk_d[gi]     = ped_hit[gi] ? (ped_pend_q[gi] | ped_req[gi])
                                                : (state_d == S_GREEN && walk_q[gi]);
        end
    endgenerate

    // Output logic
    always_comb begin
        phase       = phase_q;
        interval    = state_q;
        remaining   = rem_q;
        walk        = walk_q;
        preempt_ack = (state_q == S_PREEMPT);
        phase_start = phase_start_q;
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// Directed bench: full-recall instance walks the phase cycle, ped walk, preemption,
// table rewrite and mid-yellow reset; a no-recall instance checks demand service and rest.
module tb_traffic_phase_scheduler;

    logic       clk = 1'b0;
    logic       reset;
    logic       cfg_we;
    logic [2:0] cfg_addr;
    logic [7:0] cfg_data;
    logic [7:0] veh_req;
    logic [3:0] ped_req;
    logic       preempt_req;
    logic [2:0] preempt_phase;

    logic [2:0] f_phase;
    logic [1:0] f_interval;
    logic [7:0] f_remaining;
    logic [3:0] f_walk;
    logic       f_ack;
    logic       f_ps;

    logic [7:0] z_veh;
    logic [2:0] z_phase;
    logic [1:0] z_interval;
    logic [7:0] z_remaining;
    logic [3:0] z_walk;
    logic       z_ack;
    logic       z_ps;

    int checks   = 0;
    int failures = 0;
    int z_starts = 0;
    int seg_n;
    logic [3:0] seg_or, seg_and;

    always #5 clk = ~clk;

    traffic_phase_scheduler #(
        .TICK_DIV(4), .YELLOW_TICKS(1), .ALLRED_TICKS(1),
        .DEFAULT_GREEN(2), .RECALL_MASK(8'hFF)
    ) u_ff (
        .clk(clk), .reset(reset),
        .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
        .veh_req(veh_req), .ped_req(ped_req),
        .preempt_req(preempt_req), .preempt_phase(preempt_phase),
        .phase(f_phase), .interval(f_interval), .remaining(f_remaining),
        .walk(f_walk), .preempt_ack(f_ack), .phase_start(f_ps)
    );

    traffic_phase_scheduler #(
        .TICK_DIV(4), .YELLOW_TICKS(1), .ALLRED_TICKS(1),
        .DEFAULT_GREEN(2), .RECALL_MASK(8'h00)
    ) u_zero (
        .clk(clk), .reset(reset),
        .cfg_we(1'b0), .cfg_addr(3'd0), .cfg_data(8'd0),
        .veh_req(z_veh), .ped_req(4'd0),
        .preempt_req(1'b0), .preempt_phase(3'd0),
        .phase(z_phase), .interval(z_interval), .remaining(z_remaining),
        .walk(z_walk), .preempt_ack(z_ack), .phase_start(z_ps)
    );

    always @(negedge clk) if (!reset && z_ps) z_starts++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s = %0d", tag, got);
        end
    endtask

    // Measures how many cycles the full-recall instance stays in (iv, ph).
    task automatic seg(input string tag, input logic [1:0] iv, input logic [2:0] ph,
                       input int exp_len);
        seg_n = 0; seg_or = 4'h0; seg_and = 4'hF;
        while (f_interval == iv && f_phase == ph && seg_n < 200) begin
            seg_n++;
            seg_or  = seg_or | f_walk;
            seg_and = seg_and & f_walk;
            @(negedge clk);
        end
        check(tag, 32'(seg_n), 32'(exp_len));
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_phase"},  32'(f_phase),     32'd0);
        check({tag, "_intv"},   32'(f_interval),  32'd2);
        check({tag, "_rem"},    32'(f_remaining), 32'd1);
        check({tag, "_walk"},   32'(f_walk),      32'd0);
        check({tag, "_ack"},    32'(f_ack),       32'd0);
        check({tag, "_pstart"}, 32'(f_ps),        32'd0);
    endtask

    initial begin
        reset = 1'b1; cfg_we = 1'b0; cfg_addr = 3'd0; cfg_data = 8'd0;
        veh_req = 8'd0; ped_req = 4'd0; preempt_req = 1'b0; preempt_phase = 3'd0;
        z_veh = 8'd0;
        repeat (3) @(negedge clk);
        check_reset_outputs("rst");

        reset = 1'b0;
        z_veh = 8'h20;
        seg("ar_init", 2'd2, 3'd0, 4);

        z_veh   = 8'h00;
        ped_req = 4'b0010;
        check("g0_pstart", 32'(f_ps),        32'd1);
        check("g0_rem",    32'(f_remaining), 32'd2);
        check("z_phase5",  32'(z_phase),     32'd5);
        check("z_green",   32'(z_interval),  32'd0);
        check("z_pstart",  32'(z_ps),        32'd1);
        seg("g0_len", 2'd0, 3'd0, 8);
        check("g0_walk", 32'(seg_or), 32'd0);
        ped_req = 4'b0000;
        seg("y0_len",  2'd1, 3'd0, 4);
        seg("ar0_len", 2'd2, 3'd0, 4);
        check("g1_intv", 32'(f_interval), 32'd0);
        seg("g1_len",  2'd0, 3'd1, 8);
        check("g1_walk", 32'(seg_or), 32'd0);
        seg("y1_len",  2'd1, 3'd1, 4);
        seg("ar1_len", 2'd2, 3'd1, 4);
        seg("g2_len",  2'd0, 3'd2, 8);
        check("g2_walk_all", 32'(seg_and), 32'd2);
        check("g2_walk_any", 32'(seg_or),  32'd2);
        seg("y2_len",  2'd1, 3'd2, 4);
        check("y2_walk", 32'(seg_or), 32'd0);
        seg("ar2_len", 2'd2, 3'd2, 4);

        check("g3_pstart", 32'(f_ps), 32'd1);
        repeat (3) @(negedge clk);
        preempt_req = 1'b1; preempt_phase = 3'd6;
        @(negedge clk);
        check("pre_trunc_intv",  32'(f_interval), 32'd1);
        check("pre_trunc_phase", 32'(f_phase),    32'd3);
        preempt_phase = 3'd2;
        seg("pre_y3",  2'd1, 3'd3, 4);
        seg("pre_ar3", 2'd2, 3'd3, 4);
        check("pre_intv",   32'(f_interval),  32'd3);
        check("pre_phase",  32'(f_phase),     32'd6);
        check("pre_ack",    32'(f_ack),       32'd1);
        check("pre_rem",    32'(f_remaining), 32'd0);
        check("pre_pstart", 32'(f_ps),        32'd1);
        repeat (5) @(negedge clk);
        check("pre_hold_intv", 32'(f_interval), 32'd3);
        check("pre_hold_ack",  32'(f_ack),      32'd1);
        preempt_req = 1'b0;
        @(negedge clk);
        check("rel_intv",  32'(f_interval), 32'd1);
        check("rel_phase", 32'(f_phase),    32'd6);
        check("rel_ack",   32'(f_ack),      32'd0);
        seg("rel_y6",  2'd1, 3'd6, 4);
        seg("rel_ar6", 2'd2, 3'd6, 4);
        check("g7_intv",   32'(f_interval), 32'd0);
        check("g7_pstart", 32'(f_ps),       32'd1);
        seg("g7_len",  2'd0, 3'd7, 8);
        seg("y7_len",  2'd1, 3'd7, 4);
        seg("ar7_len", 2'd2, 3'd7, 4);

        cfg_we = 1'b1; cfg_addr = 3'd0; cfg_data = 8'd0;
        @(negedge clk);
        cfg_we = 1'b0;
        check("cfg_rem_kept", 32'(f_remaining), 32'd2);
        seg("cfg_g0_rest", 2'd0, 3'd0, 7);
        seg("cfg_y0",  2'd1, 3'd0, 4);
        seg("cfg_ar0", 2'd2, 3'd0, 4);
        for (int p = 1; p < 8; p++) begin
            seg($sformatf("rnd_g%0d", p),  2'd0, 3'(p), 8);
            seg($sformatf("rnd_y%0d", p),  2'd1, 3'(p), 4);
            seg($sformatf("rnd_ar%0d", p), 2'd2, 3'(p), 4);
        end
        check("g0_short_rem", 32'(f_remaining), 32'd1);
        seg("g0_short_len", 2'd0, 3'd0, 4);
        seg("y0b_len",  2'd1, 3'd0, 4);
        seg("ar0b_len", 2'd2, 3'd0, 4);
        seg("g1b_len",  2'd0, 3'd1, 8);

        check("z_rest_phase", 32'(z_phase),     32'd5);
        check("z_rest_intv",  32'(z_interval),  32'd0);
        check("z_rest_rem",   32'(z_remaining), 32'd1);
        check("z_served_once", 32'(z_starts),   32'd1);
        check("z_walk",       32'(z_walk),      32'd0);

        @(negedge clk);
        check("midy_intv", 32'(f_interval), 32'd1);
        check("midy_phase", 32'(f_phase),   32'd1);
        reset = 1'b1;
        #1;
        check_reset_outputs("midy_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/traffic_phase_scheduler.md
TRAFFIC_PHASE_SCHEDULER -- requirements
Module: traffic_phase_scheduler

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 50000000; clock cycles per timing tick.
REQ-002 The block SHALL have parameter YELLOW_TICKS, default 3; yellow interval length in ticks.
REQ-003 The block SHALL have parameter ALLRED_TICKS, default 1; all-red clearance length in ticks.
REQ-004 The block SHALL have parameter DEFAULT_GREEN, default 10; reset value of every green-duration entry, in ticks.
REQ-005 The block SHALL have parameter RECALL_MASK, default 8'hFF; phases served every cycle regardless of demand.
REQ-006 The block SHALL have port clk, input, 1 bit; clock.
REQ-007 The block SHALL have port reset, input, 1 bit; reset, asynchronous, active-high.
REQ-008 The block SHALL have port cfg_we, input, 1 bit; green-duration table write strobe.
REQ-009 The block SHALL have port cfg_addr, input, 3 bits; phase index for the table write.
REQ-010 The block SHALL have port cfg_data, input, 8 bits; green duration in ticks.
REQ-011 The block SHALL have port veh_req, input, 8 bits; per-phase vehicle sensor level.
REQ-012 The block SHALL have port ped_req, input, 4 bits; pedestrian button level; crossing i belongs to phase 2i.
REQ-013 The block SHALL have port preempt_req, input, 1 bit; emergency preemption request level.
REQ-014 The block SHALL have port preempt_phase, input, 3 bits; phase to force green during preemption.
REQ-015 The block SHALL have port phase, output, 3 bits; current phase index.
REQ-016 The block SHALL have port interval, output, 2 bits; 00 GREEN, 01 YELLOW, 10 ALLRED, 11 PREEMPT.
REQ-017 The block SHALL have port remaining, output, 8 bits; ticks left in the current interval, for the countdown display.
REQ-018 The block SHALL have port walk, output, 4 bits; pedestrian walk indications.
REQ-019 The block SHALL have port preempt_ack, output, 1 bit; high while preemption green is held.
REQ-020 The block SHALL have port phase_start, output, 1 bit; one-cycle pulse on each entry to GREEN or PREEMPT.

Function
REQ-021 The tick prescaler SHALL count 0..TICK_DIV-1, pulse tick on the terminal count, and restart at 0 on every interval entry, so that an interval of D ticks lasts exactly D*TICK_DIV cycles.
REQ-022 On interval entry, remaining SHALL load the interval length; a length of 0 SHALL be loaded as 1.
REQ-023 On each tick, remaining SHALL decrement when greater than 1; a tick with remaining==1 SHALL end the interval.
REQ-024 The FSM SHALL sequence GREEN -> YELLOW -> ALLRED -> GREEN(next); GREEN loads table[phase], YELLOW loads YELLOW_TICKS, ALLRED loads ALLRED_TICKS.
REQ-025 veh_pend[p] SHALL set when veh_req[p] is sampled high; it SHALL clear on entry to GREEN of phase p, and set-and-clear in the same cycle SHALL leave it clear.
REQ-026 Next-phase selection SHALL search phase+1, phase+2, ... wrapping, with the current phase last, for the first p where veh_pend[p] or RECALL_MASK[p] is set.
REQ-027 If the selected phase equals the current phase at green expiry, green SHALL reload table[phase] without YELLOW or ALLRED and SHALL pulse phase_start.
REQ-028 If no phase qualifies, the FSM SHALL rest in GREEN with remaining=1 and re-evaluate on every tick.
REQ-029 ped_pend[i] SHALL set on ped_req[i] high; walk[i] SHALL assert for the whole GREEN of phase 2i when ped_pend[i] was set at entry, and ped_pend[i] SHALL clear at that entry.
REQ-030 A ped_req[i] during an active walk SHALL stay pending for the next service; walk SHALL be 0 outside GREEN.
REQ-031 cfg_we SHALL write table[cfg_addr]=cfg_data in one cycle; a write SHALL NOT alter a remaining value already loaded.
REQ-032 preempt_req seen in GREEN of a phase other than preempt_phase SHALL truncate green the next cycle into YELLOW, then ALLRED, then PREEMPT at preempt_phase.
REQ-033 preempt_req seen in GREEN of preempt_phase SHALL enter PREEMPT the next cycle; preempt_req seen in YELLOW or ALLRED SHALL let the interval finish, then proceed to PREEMPT.
REQ-034 PREEMPT SHALL hold preempt_ack=1 and remaining=0 while preempt_req stays high.
REQ-035 On preempt_req low, PREEMPT SHALL go to YELLOW then ALLRED, and selection SHALL resume from preempt_phase.
REQ-036 preempt_phase SHALL be sampled when the preemption starts; later changes SHALL be ignored until the next preemption.

Reset
REQ-037 Reset SHALL force phase=0, interval=ALLRED, remaining=ALLRED_TICKS, walk=0, preempt_ack=0, phase_start=0, prescaler=0, all pend bits=0, and every table entry=DEFAULT_GREEN.
REQ-038 After reset release, ALLRED SHALL complete and selection SHALL start the search at phase 0 inclusive.
REQ-039 Reset mid-interval SHALL abandon the interval with no completion pulses.

Verification (TICK_DIV=4, DEFAULT_GREEN=2, YELLOW_TICKS=1, ALLRED_TICKS=1)
REQ-040 Bench SHALL cover reset release with RECALL_MASK=FF -> ALLRED 4 cycles, GREEN phase 0 for 8 cycles, YELLOW 4, ALLRED 4, then GREEN phase 1.
REQ-041 Bench SHALL cover RECALL_MASK=0 with veh_req=8'h20 pulsed once -> phase 5 served once, then rest in GREEN phase 5 with remaining=1.
REQ-042 Bench SHALL cover ped_req[1] pulsed during phase 0 green -> walk[1] high for exactly the GREEN of phase 2, walk=0 elsewhere.
REQ-043 Bench SHALL cover preempt_req raised mid-green of phase 3 with preempt_phase=6 -> YELLOW next cycle, ALLRED, interval=PREEMPT with phase=6 and preempt_ack=1; release -> YELLOW, ALLRED, GREEN phase 7.
REQ-044 Bench SHALL cover cfg write table[0]=0 during phase 0 green -> current green unchanged, next phase 0 green lasts 1 tick.
REQ-045 Bench SHALL cover reset asserted mid-YELLOW -> all outputs at reset values in the same cycle.
